qarctan_arb: RTL
================

QARCTAN_ARB -- requirements
Module: qarctan_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of every sample word (signed, two's complement).
REQ-002 Parameter TAG_DEPTH, default 4: maximum samples in flight in the shared qarctan unit; power of two, >=2.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  when high, new samples may be issued to the shared unit.
REQ-006 c0_rd_en  output  1  pops one sample from both channel-0 y and x FIFOs (show-ahead).
REQ-007 c0_y_empty, c0_x_empty  input  1 each  channel-0 y and x FIFOs are empty.
REQ-008 c0_y_dout, c0_x_dout  input  DATA_WIDTH each  channel-0 y and x head words.
REQ-009 c1_rd_en, c1_y_empty, c1_x_empty, c1_y_dout, c1_x_dout: same as REQ-006..008, for channel 1.
REQ-010 u_wr_en  output  1  writes one y/x pair into the shared unit's input FIFOs.
REQ-011 u_full  input  1  either shared-unit input FIFO is full.
REQ-012 u_y_din, u_x_din  output  DATA_WIDTH each  y and x words presented to the shared unit.
REQ-013 u_rd_en  output  1  pops one angle from the shared unit's output FIFO.
REQ-014 u_empty  input  1  shared-unit output FIFO is empty.
REQ-015 u_dout  input  DATA_WIDTH  head angle from the shared unit.
REQ-016 o0_wr_en, o1_wr_en  output  1 each  writes the angle to the channel-0 or channel-1 output FIFO.
REQ-017 o0_full, o1_full  input  1 each  channel-0 or channel-1 output FIFO is full.
REQ-018 o0_din, o1_din  output  DATA_WIDTH each  angle word for the channel-0 or channel-1 output FIFO.
REQ-019 busy  output  1  high while the tag count is greater than 0.

Function
REQ-020 Channel k is eligible when cK_y_empty=0 and cK_x_empty=0.
REQ-021 Issue condition: enable=1, u_full=0, tag count < TAG_DEPTH, and at least one channel eligible.
REQ-022 Issue arbitration: round-robin using a 1-bit priority pointer.
  - If both channels are eligible, the channel named by the pointer wins.
  - If one channel is eligible, it wins.
  - The pointer moves to the other channel only on a cycle in which a grant is made.
REQ-023 On issue, in the same cycle (combinational):
  - u_wr_en=1, cK_rd_en=1 for the winner only.
  - u_y_din/u_x_din = the winner's head words.
  - The winner's index is pushed into the tag FIFO at the next edge.
REQ-024 When no issue occurs: u_wr_en=0, both cK_rd_en=0, u_y_din=u_x_din=0.
REQ-025 Tag FIFO: internal circular buffer, TAG_DEPTH entries of 1 bit.
  - Read/write pointers wrap modulo TAG_DEPTH.
  - Count register has width clog2(TAG_DEPTH)+1.
REQ-026 Return condition: u_empty=0, tag count > 0, and the output FIFO named by the head tag is not full.
REQ-027 On return, in the same cycle (combinational):
  - u_rd_en=1.
  - oK_wr_en=1 for the head-tag channel only.
  - oK_din = u_dout, passed unmodified.
  - The tag FIFO is popped at the next edge.
REQ-028 When no return occurs: u_rd_en=0, o0_wr_en=o1_wr_en=0, o0_din=o1_din=0.
REQ-029 A non-selected oK_din is 0.
REQ-030 Results are returned strictly in issue order; a full output on the head channel stalls all returns (head-of-line blocking).
REQ-031 Simultaneous issue and return in one cycle are both allowed; the count is unchanged.
  - An issue is allowed when count=TAG_DEPTH only if a return occurs in the same cycle.
REQ-032 u_empty=0 with count=0 is an error condition; the block does not read and holds u_rd_en=0.
REQ-033 Deasserting enable stops issues only; in-flight returns continue until busy=0.
REQ-034 Latency: issue is a combinational 0-cycle handshake; return is forwarded in the same cycle u_dout becomes valid and REQ-026 holds.

Reset
REQ-035 While reset=1:
  - Priority pointer = channel 0.
  - Tag pointers and count = 0; busy=0.
  - All rd_en/wr_en outputs = 0; all data outputs = 0.
REQ-036 Reset asserted mid-operation discards all tags; the environment flushes the shared unit concurrently.

Verification
REQ-037 Both channels eligible, enable=1, u_full=0, 4 cycles -> grants 0,1,0,1 on c0_rd_en/c1_rd_en; u_y_din equals the granted head y.
REQ-038 Only channel 1 eligible for 3 cycles, then both eligible -> grants 1,1,1, then 0.
REQ-039 TAG_DEPTH=4, u_empty held 1, 6 issue attempts -> exactly 4 u_wr_en pulses; busy=1; 5th attempt blocked until one return occurs.
REQ-040 Tags [0,1,0], unit returns 100, -200, 300, o1_full=1 on the second return for 2 cycles -> o0 gets 100; o1 gets -200 after the stall; o0 gets 300 only after -200 is written.
REQ-041 count=4 with a return and an eligible request in the same cycle -> both occur; count stays 4.
REQ-042 reset pulsed with 3 tags in flight -> busy=0 and all strobes 0 next cycle; the first issue after reset goes to channel 0.

Source files
------------

// File: rtl/qarctan_arb.sv
// qarctan_arb: shares one qarctan unit between two sample channels.
// Issues y/x pairs round-robin into the shared unit, tags each issue with its
// source channel, and steers returned angles back to the right output FIFO in
// strict issue order.
module qarctan_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  c0_rd_en,
    input  logic                  c0_y_empty,
    input  logic                  c0_x_empty,
    input  logic [DATA_WIDTH-1:0] c0_y_dout,
    input  logic [DATA_WIDTH-1:0] c0_x_dout,
    output logic                  c1_rd_en,
    input  logic                  c1_y_empty,
    input  logic                  c1_x_empty,
    input  logic [DATA_WIDTH-1:0] c1_y_dout,
    input  logic [DATA_WIDTH-1:0] c1_x_dout,
    output logic                  u_wr_en,
    input  logic                  u_full,
    output logic [DATA_WIDTH-1:0] u_y_din,
    output logic [DATA_WIDTH-1:0] u_x_din,
    output logic                  u_rd_en,
    input  logic                  u_empty,
    input  logic [DATA_WIDTH-1:0] u_dout,
    output logic                  o0_wr_en,
    input  logic                  o0_full,
    output logic [DATA_WIDTH-1:0] o0_din,
    output logic                  o1_wr_en,
    input  logic                  o1_full,
    output logic [DATA_WIDTH-1:0] o1_din,
    output logic                  busy
);

    localparam int              PW       = $clog2(TAG_DEPTH);
    localparam logic [PW:0]     LP_DEPTH = (PW + 1)'(TAG_DEPTH);

    logic                 r_prio;
    logic [TAG_DEPTH-1:0] r_tags;
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic [PW:0]          r_count;

    logic w_elig0;
    logic w_elig1;
    logic w_headTag;
    logic w_ret;
    logic w_room;
    logic w_issue;
    logic w_winner;

    // Decide whether a return and/or an issue happens this cycle, and who wins.
    // A full tag FIFO can still accept an issue when a return frees a slot now.
    always_comb begin
        w_elig0   = !c0_y_empty && !c0_x_empty;
        w_elig1   = !c1_y_empty && !c1_x_empty;
        w_headTag = r_tags[r_rptr];
        w_ret     = !reset && !u_empty && (r_count != '0)
                    && !(w_headTag ? o1_full : o0_full);
        w_room    = (r_count < LP_DEPTH) || w_ret;
        w_issue   = !reset && enable && !u_full && w_room && (w_elig0 || w_elig1);
        w_winner  = (w_elig0 && w_elig1) ? r_prio : w_elig1;
    end

    // Drive the handshake strobes and data; unselected data buses read as zero.
    always_comb begin
        c0_rd_en = 1'b0;
        c1_rd_en = 1'b0;
        u_wr_en  = 1'b0;
        u_y_din  = '0;
        u_x_din  = '0;
        u_rd_en  = 1'b0;
        o0_wr_en = 1'b0;
        o1_wr_en = 1'b0;
        o0_din   = '0;
        o1_din   = '0;
        if (w_issue) begin
            u_wr_en = 1'b1;
            if (w_winner) begin
                c1_rd_en = 1'b1;
                u_y_din  = c1_y_dout;
                u_x_din  = c1_x_dout;
            end else begin
                c0_rd_en = 1'b1;
                u_y_din  = c0_y_dout;
                u_x_din  = c0_x_dout;
            end
        end
        if (w_ret) begin
            u_rd_en = 1'b1;
            if (w_headTag) begin
                o1_wr_en = 1'b1;
                o1_din   = u_dout;
            end else begin
                o0_wr_en = 1'b1;
                o0_din   = u_dout;
            end
        end
    end

    // Round-robin pointer: after a grant, favour the channel that did not win.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prio <= 1'b0;
        end else if (w_issue) begin
            r_prio <= ~w_winner;
        end
    end

    // Tag storage and write pointer: record the source channel of every issue.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tags <= '0;
            r_wptr <= '0;
        end else if (w_issue) begin
            r_tags[r_wptr] <= w_winner;
            r_wptr         <= r_wptr + 1'b1;
        end
    end

    // Tag read pointer advances once per returned angle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rptr <= '0;
        end else if (w_ret) begin
            r_rptr <= r_rptr + 1'b1;
        end
    end

    // In-flight count; a simultaneous issue and return leaves it unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_issue, w_ret})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign busy = (r_count != '0);

endmodule
